alu_req_serializer: RTL

ALU_REQ_SERIALIZER -- requirements
Module: alu_req_serializer

---
 rtl/alu_req_serializer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/alu_req_serializer.sv
`default_nettype none
// ============================================================================
// Module   : alu_req_serializer
// Brief    : Buffers ALU requests in a 2-deep FIFO and issues each one as a
//            two-phase serial opcode/operand transaction, then holds the response.
// Revision : 1.0
// ============================================================================
module alu_req_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    output logic                  opcode_valid,
    output logic                  opcode,
    output logic [DATA_WIDTH-1:0] data,
    input  logic                  done,
    input  logic [DATA_WIDTH-1:0] result,
    input  logic                  overflow,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_overflow,
    output logic                  rsp_timeout,
    output logic                  proto_err
);

    localparam int         c_ENTRY_W = 2 + 2 * DATA_WIDTH;
    localparam logic [3:0] c_TIMEOUT = 4'(TIMEOUT);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_OPA  = 3'd1;
    localparam logic [2:0] c_OPB  = 3'd2;
    localparam logic [2:0] c_WAIT = 3'd3;
    localparam logic [2:0] c_RESP = 3'd4;

    logic [c_ENTRY_W-1:0]  r_fifo [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic                  r_req_ready;

    logic [2:0]            r_state;
    logic [3:0]            r_wait_cnt;
    logic                  r_op_hi;
    logic [DATA_WIDTH-1:0] r_b;
    logic                  r_opcode_valid;
    logic                  r_opcode;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_result;
    logic                  r_rsp_overflow;
    logic                  r_rsp_timeout;
    logic                  r_proto_err;

    logic                  w_push;
    logic                  w_pop;
    logic [1:0]            w_count_next;
    logic [c_ENTRY_W-1:0]  w_head;
    logic [1:0]            w_head_op;
    logic [DATA_WIDTH-1:0] w_head_a;
    logic [DATA_WIDTH-1:0] w_head_b;

    assign w_push    = req_valid & r_req_ready;
    // A new transaction may start from IDLE, or straight out of RESP as the response is taken.
    assign w_pop     = (r_count != 2'd0) &&
                       ((r_state == c_IDLE) || ((r_state == c_RESP) && rsp_ready));
    assign w_head    = r_fifo[r_rd_ptr];
    assign w_head_op = w_head[c_ENTRY_W-1 -: 2];
    assign w_head_a  = w_head[2*DATA_WIDTH-1 -: DATA_WIDTH];
    assign w_head_b  = w_head[DATA_WIDTH-1:0];

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo[i] <= '0;
            end
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
            r_req_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= {req_op, req_a, req_b};
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count     <= w_count_next;
            r_req_ready <= (w_count_next != 2'd2);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= c_IDLE;
            r_wait_cnt     <= 4'd0;
            r_op_hi        <= 1'b0;
            r_b            <= '0;
            r_opcode_valid <= 1'b0;
            r_opcode       <= 1'b0;
            r_data         <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_result   <= '0;
            r_rsp_overflow <= 1'b0;
            r_rsp_timeout  <= 1'b0;
            r_proto_err    <= 1'b0;
        end else begin
            if (done && (r_state != c_WAIT)) begin
                r_proto_err <= 1'b1;
            end
            case (r_state)
                c_IDLE: begin
                    r_state <= c_IDLE;
                end
                c_OPA: begin
                    r_state  <= c_OPB;
                    r_opcode <= r_op_hi;
                    r_data   <= r_b;
                end
                c_OPB: begin
                    r_state        <= c_WAIT;
                    r_opcode_valid <= 1'b0;
                    r_opcode       <= 1'b0;
                    r_data         <= '0;
                    r_wait_cnt     <= 4'd1;
                end
                c_WAIT: begin
                    if (done) begin
                        r_state        <= c_RESP;
                        r_wait_cnt     <= 4'd0;
                        r_rsp_valid    <= 1'b1;
                        r_rsp_result   <= result;
                        r_rsp_overflow <= overflow;
                        r_rsp_timeout  <= 1'b0;
                    end else if (r_wait_cnt == c_TIMEOUT) begin
                        r_state        <= c_RESP;
                        r_wait_cnt     <= 4'd0;
                        r_rsp_valid    <= 1'b1;
                        r_rsp_result   <= '0;
                        r_rsp_overflow <= 1'b0;
                        r_rsp_timeout  <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                c_RESP: begin
                    if (rsp_ready) begin
                        r_state        <= c_IDLE;
                        r_rsp_valid    <= 1'b0;
                        r_rsp_result   <= '0;
                        r_rsp_overflow <= 1'b0;
                        r_rsp_timeout  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
            // Starting a transaction overrides the per-state next-state above.
            if (w_pop) begin
                r_state        <= c_OPA;
                r_opcode_valid <= 1'b1;
                r_opcode       <= w_head_op[0];
                r_data         <= w_head_a;
                r_op_hi        <= w_head_op[1];
                r_b            <= w_head_b;
            end
        end
    end

    assign req_ready    = r_req_ready;
    assign opcode_valid = r_opcode_valid;
    assign opcode       = r_opcode;
    assign data         = r_data;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_result   = r_rsp_result;
    assign rsp_overflow = r_rsp_overflow;
    assign rsp_timeout  = r_rsp_timeout;
    assign proto_err    = r_proto_err;

endmodule
`default_nettype wire
